// File: rtl/vector_tile_buffer.sv
// Banked vector tile store with per-buffer auto-incrementing read/write tile pointers.
// Optional macro VECBUF_WR_FORWARD_EN: same-address read+write returns the write data.
module vector_tile_buffer #(
    parameter int DATA_WIDTH    = 16,
    parameter int TILE_ELEMS    = 8,
    parameter int NUM_BUFFERS   = 8,
    parameter int TILES_PER_BUF = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         vec_read_enable,
    input  logic [4:0]                   vec_read_buffer_id,
    output logic signed [DATA_WIDTH-1:0] vec_read_tile [TILE_ELEMS],
    output logic                         vec_read_valid,
    output logic                         vec_read_error,
    input  logic                         vec_write_enable,
    input  logic [4:0]                   vec_write_buffer_id,
    input  logic signed [DATA_WIDTH-1:0] vec_write_tile [TILE_ELEMS],
    input  logic                         ptr_clear,
    input  logic [4:0]                   ptr_clear_buffer_id,
    input  logic                         ptr_clear_all
);

    localparam int PTR_W = (TILES_PER_BUF > 1) ? $clog2(TILES_PER_BUF) : 1;
    localparam int BUF_W = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1;
    localparam logic [5:0] NUM_BUF_ID = 6'(NUM_BUFFERS);
    localparam logic [PTR_W-1:0] LAST_TILE = PTR_W'(TILES_PER_BUF - 1);

    logic signed [DATA_WIDTH-1:0] mem [NUM_BUFFERS][TILES_PER_BUF][TILE_ELEMS];
    logic [PTR_W-1:0] rd_ptr [NUM_BUFFERS];
    logic [PTR_W-1:0] wr_ptr [NUM_BUFFERS];

    logic rd_in_range, wr_in_range, rd_hit, wr_hit;
    logic [BUF_W-1:0] rd_idx, wr_idx;
    logic signed [DATA_WIDTH-1:0] rd_data [TILE_ELEMS];

    assign rd_in_range = ({1'b0, vec_read_buffer_id} < NUM_BUF_ID);
    assign wr_in_range = ({1'b0, vec_write_buffer_id} < NUM_BUF_ID);
    assign rd_hit      = vec_read_enable && rd_in_range;
    assign wr_hit      = vec_write_enable && wr_in_range;
    assign rd_idx      = vec_read_buffer_id[BUF_W-1:0];
    assign wr_idx      = vec_write_buffer_id[BUF_W-1:0];

    always_comb begin
        rd_data = mem[rd_idx][rd_ptr[rd_idx]];
`ifdef VECBUF_WR_FORWARD_EN
        if (wr_hit && (wr_idx == rd_idx) && (wr_ptr[wr_idx] == rd_ptr[rd_idx]))
            rd_data = vec_write_tile;
`endif
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_hit)
            mem[wr_idx][wr_ptr[wr_idx]] <= vec_write_tile;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_read_valid <= 1'b0;
            vec_read_error <= 1'b0;
            for (int i = 0; i < TILE_ELEMS; i++)
                vec_read_tile[i] <= '0;
            for (int b = 0; b < NUM_BUFFERS; b++) begin
                rd_ptr[b] <= '0;
                wr_ptr[b] <= '0;
            end
        end else begin
            vec_read_valid <= vec_read_enable;
            vec_read_error <= vec_read_enable && !rd_in_range;
            if (rd_hit)
                vec_read_tile <= rd_data;
            else
                for (int i = 0; i < TILE_ELEMS; i++)
                    vec_read_tile[i] <= '0;
            // A clear wins over any increment in the same cycle.
            for (int b = 0; b < NUM_BUFFERS; b++) begin
                if (ptr_clear_all || (ptr_clear && (ptr_clear_buffer_id == 5'(b)))) begin
                    rd_ptr[b] <= '0;
                    wr_ptr[b] <= '0;
                end else begin
                    if (rd_hit && (rd_idx == BUF_W'(b)))
                        rd_ptr[b] <= (rd_ptr[b] == LAST_TILE) ? '0 : rd_ptr[b] + 1'b1;
                    if (wr_hit && (wr_idx == BUF_W'(b)))
                        wr_ptr[b] <= (wr_ptr[b] == LAST_TILE) ? '0 : wr_ptr[b] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_tile_buffer.sv
// Directed bench for vector_tile_buffer: array-based reference model checked every cycle,
// plus literal expectations at key points of the sequence.
module tb_vector_tile_buffer;

    localparam int DW = 16;
    localparam int TE = 8;
    localparam int NB = 8;
    localparam int TPB = 32;

    logic clk = 1'b0;
    logic rst;
    logic re, we, pc, pca;
    logic [4:0] rid, wid, cid;
    logic signed [DW-1:0] wt [TE];
    logic signed [DW-1:0] rt [TE];
    logic rv, rerr;

    int total = 0;
    int bad = 0;

    vector_tile_buffer #(.DATA_WIDTH(DW), .TILE_ELEMS(TE), .NUM_BUFFERS(NB), .TILES_PER_BUF(TPB)) dut (
        .clk(clk), .rst(rst),
        .vec_read_enable(re), .vec_read_buffer_id(rid),
        .vec_read_tile(rt), .vec_read_valid(rv), .vec_read_error(rerr),
        .vec_write_enable(we), .vec_write_buffer_id(wid), .vec_write_tile(wt),
        .ptr_clear(pc), .ptr_clear_buffer_id(cid), .ptr_clear_all(pca)
    );

    always #5 clk = ~clk;

    // Reference model: plain arrays of stored tiles and pointer counters.
    int m_mem [NB][TPB][TE];
    bit m_written [NB][TPB];
    int m_rd [NB];
    int m_wr [NB];
    bit started = 0;
    bit exp_valid, exp_err, exp_chk;
    int exp_tile [TE];

    always @(posedge clk) begin
        started = 1;
        if (rst) begin
            exp_valid = 0; exp_err = 0; exp_chk = 1;
            for (int i = 0; i < TE; i++) exp_tile[i] = 0;
            for (int b = 0; b < NB; b++) begin m_rd[b] = 0; m_wr[b] = 0; end
        end else begin
            exp_valid = re;
            exp_err = re && (int'(rid) >= NB);
            exp_chk = 0;
            if (re && exp_err) begin
                exp_chk = 1;
                for (int i = 0; i < TE; i++) exp_tile[i] = 0;
            end else if (re) begin
                exp_chk = m_written[rid][m_rd[rid]];
                for (int i = 0; i < TE; i++) exp_tile[i] = m_mem[rid][m_rd[rid]][i];
`ifdef VECBUF_WR_FORWARD_EN
                if (we && wid == rid && m_wr[wid] == m_rd[rid]) begin
                    exp_chk = 1;
                    for (int i = 0; i < TE; i++) exp_tile[i] = int'(wt[i]);
                end
`endif
            end
            if (we && int'(wid) < NB) begin
                for (int i = 0; i < TE; i++) m_mem[wid][m_wr[wid]][i] = int'(wt[i]);
                m_written[wid][m_wr[wid]] = 1;
                m_wr[wid] = (m_wr[wid] + 1) % TPB;
            end
            if (re && int'(rid) < NB) m_rd[rid] = (m_rd[rid] + 1) % TPB;
            for (int b = 0; b < NB; b++)
                if (pca || (pc && int'(cid) == b)) begin m_rd[b] = 0; m_wr[b] = 0; end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            bit tile_ok;
            total++;
            if (rv !== exp_valid) begin
                bad++; $display("FAIL model_valid t=%0t actual=%b required=%b", $time, rv, exp_valid);
            end
            total++;
            if (rerr !== exp_err) begin
                bad++; $display("FAIL model_error t=%0t actual=%b required=%b", $time, rerr, exp_err);
            end
            if (exp_chk) begin
                tile_ok = 1;
                for (int i = 0; i < TE; i++) if (int'(rt[i]) !== exp_tile[i]) tile_ok = 0;
                total++;
                if (!tile_ok) begin
                    bad++; $display("FAIL model_tile t=%0t actual[0]=%0d required[0]=%0d", $time, rt[0], exp_tile[0]);
                end
            end
        end
    end

    task automatic fill_seq(input int base);
        for (int i = 0; i < TE; i++) wt[i] = DW'(base + i);
    endtask

    task automatic fill_const(input int v);
        for (int i = 0; i < TE; i++) wt[i] = DW'(v);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++; $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic check_seq(input string name, input int base);
        bit ok = 1;
        for (int i = 0; i < TE; i++) if (int'(rt[i]) !== base + i) ok = 0;
        total++;
        if (!ok) begin
            bad++; $display("FAIL %s actual[0]=%0d required[0]=%0d", name, rt[0], base);
        end
    endtask

    task automatic check_const(input string name, input int v);
        bit ok = 1;
        for (int i = 0; i < TE; i++) if (int'(rt[i]) !== v) ok = 0;
        total++;
        if (!ok) begin
            bad++; $display("FAIL %s actual[0]=%0d required=%0d", name, rt[0], v);
        end
    endtask

    initial begin
        rst = 1; re = 0; we = 0; pc = 0; pca = 0; rid = 0; wid = 0; cid = 0;
        fill_const(0);
        tick(); tick();
        check_bit("rst_valid", rv, 1'b0);
        check_bit("rst_error", rerr, 1'b0);
        check_const("rst_tile", 0);
        rst = 0;

        for (int t = 0; t < 4; t++) begin we = 1; wid = 2; fill_seq(t * 8); tick(); end
        we = 0;
        for (int t = 0; t < 4; t++) begin
            re = 1; rid = 2; tick();
            check_bit("b2b_valid", rv, 1'b1);
            check_seq("b2b_tile", t * 8);
        end
        re = 0; tick();
        check_bit("valid_drop", rv, 1'b0);

        for (int t = 0; t < 4; t++) begin we = 1; wid = 1; fill_seq(100 + t * 8); tick(); end
        wid = 3; fill_const(-5); tick();
        we = 0;
        pca = 1; tick(); pca = 0;

        for (int k = 0; k <= TPB; k++) begin we = 1; wid = 0; fill_seq(1000 + k * 8); tick(); end
        we = 0;
        re = 1; rid = 0; tick();
        check_seq("wrap_tile0", 1000 + TPB * 8);

        rid = 9; tick();
        check_bit("oor_valid", rv, 1'b1);
        check_bit("oor_error", rerr, 1'b1);
        check_const("oor_tile", 0);
        re = 0;
        we = 1; wid = 9; fill_const(777); tick(); we = 0;
        re = 1; rid = 1; tick();
        check_seq("buf1_after_oor_wr", 100);
        check_bit("buf1_error", rerr, 1'b0);
        tick(); tick();
        pc = 1; cid = 1; tick();
        check_seq("clear_same_cycle", 124);
        pc = 0; tick();
        check_seq("after_clear", 100);
        re = 0;

        re = 1; rid = 3; we = 1; wid = 3; fill_const(7); tick();
`ifdef VECBUF_WR_FORWARD_EN
        check_const("same_addr_rw", 7);
`else
        check_const("same_addr_rw", -5);
`endif
        re = 0; we = 0;
        pc = 1; cid = 3; tick(); pc = 0;
        re = 1; rid = 3; tick();
        check_const("same_addr_new", 7);

        rid = 2; tick();
        check_seq("pre_rst_t0", 0);
        tick();
        check_seq("pre_rst_t1", 8);
        rst = 1; tick();
        check_bit("mid_rst_valid", rv, 1'b0);
        check_bit("mid_rst_error", rerr, 1'b0);
        check_const("mid_rst_tile", 0);
        rst = 0; tick();
        check_seq("post_rst_buf2", 0);
        rid = 0; tick();
        check_seq("post_rst_buf0", 1000 + TPB * 8);
        re = 0; tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
